data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder.sv | 203 ++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-side memory for the load/store unit.
// Accepts one request at a time over a valid/ready handshake. The request
// is held for WAIT_CYCLES wait states and then committed to an internal
// word-addressed RAM with byte enables. Load data, or a completion, is
// returned with an error flag over a valid/ready response channel.
//
// Handshake semantics (both channels): a transfer happens at a rising edge
// where valid && ready are both high. The source holds valid and its
// payload stable until that edge. The sink may lower ready at any time.
// Here req_ready is high only in IDLE with rst low. resp_valid is high
// only in RESP, and resp_rdata/resp_err do not change until the response
// is accepted.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [31:0]             req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;

  // Index of the last wait-state edge. The commit happens on that edge.
  localparam logic [3:0] LAST_WAIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // FSM state, exposed by name for checkers bound to this module.
  state_t state;
  state_t state_next;

  logic [3:0] wait_cnt;

  // Request fields latched at acceptance
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [NUM_BYTES-1:0]    be_q;
  logic                    err_q;

  // Word storage. It is not cleared by reset.
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Decode of the incoming request
  logic                  req_misaligned;
  logic                  req_out_of_range;
  logic                  req_err;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic [31:0]           req_addr_hi;

  // Handshake and commit strobes
  logic accept;
  logic wait_done;
  logic commit;
  logic resp_done;

  // Operands of the access being committed this cycle
  logic                  c_we;
  logic [ADDR_WIDTH-1:0] c_idx;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic [NUM_BYTES-1:0]  c_be;
  logic                  c_err;

  // Address checks. Any bit above the RAM range makes the request an error,
  // so addresses never alias onto lower words.
  assign req_addr_hi      = req_addr >> (ADDR_WIDTH + 2);
  assign req_misaligned   = |req_addr[1:0];
  assign req_out_of_range = |req_addr_hi;
  assign req_err          = req_misaligned | req_out_of_range;
  assign req_idx          = req_addr[ADDR_WIDTH+1:2];

  assign accept    = req_valid & req_ready;
  assign wait_done = (state == WAIT) && (wait_cnt == LAST_WAIT);
  assign commit    = (accept & NO_WAIT) | wait_done;
  assign resp_done = (state == RESP) && resp_ready;

  // Commit operands. With zero wait states the access commits on the
  // acceptance edge, so it uses the live request fields.
  always_comb begin
    c_we    = we_q;
    c_idx   = idx_q;
    c_wdata = wdata_q;
    c_be    = be_q;
    c_err   = err_q;
    if (state == IDLE) begin
      c_we    = req_we;
      c_idx   = req_idx;
      c_wdata = req_wdata;
      c_be    = req_be;
      c_err   = req_err;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = ~rst;
        if (accept) begin
          state_next = NO_WAIT ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (wait_done) begin
          state_next = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Wait-state counter. It restarts on every acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 4'd0;
    end else if (accept || wait_done) begin
      wait_cnt <= 4'd0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Latch the request at acceptance. Request inputs are ignored afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we;
      idx_q   <= req_idx;
      wdata_q <= req_wdata;
      be_q    <= req_be;
      err_q   <= req_err;
    end
  end

  // Response payload: captured at commit, cleared on the response handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (commit) begin
      resp_rdata <= (!c_we && !c_err) ? mem[c_idx] : '0;
      resp_err   <= c_err;
    end else if (resp_done) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end
  end

  // Byte-enabled RAM write. A store aborted by reset before commit never
  // reaches this point.
  always_ff @(posedge clk) begin
    if (!rst && commit && c_we && !c_err) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (c_be[b]) begin
          mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder. Two instances are used: one with two wait
// states and one with none. Each is checked against a word-array memory
// model and the latency and handshake rules.
module tb_data_mem_responder;

  logic        clk;
  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [3:0]  req_be     [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int          wc [2];
  int          tests_run;
  int          tests_failed;
  logic [31:0] model_mem [2][256];
  logic [32:0] exp_q[$];
  logic [31:0] got;

  data_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  data_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // An error is a misaligned address or any address bit above the 1 KiB window.
  function automatic logic model_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:10] != 22'h0);
  endfunction

  task automatic check_idle_outputs(input int n, input string tag);
    check({tag, "_resp_valid"}, 32'(resp_valid[n]), 32'h0);
    check({tag, "_resp_rdata"}, resp_rdata[n], 32'h0);
    check({tag, "_resp_err"},   32'(resp_err[n]), 32'h0);
  endtask

  // One complete transaction. The task is entered and left at a falling edge.
  task automatic do_txn(input int n, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int hold, output logic [31:0] rdata_out);
    int          guard;
    logic        e;
    logic [7:0]  idx;
    logic [32:0] exp;
    logic [31:0] held_rdata;
    logic        held_err;
    rdata_out = 32'h0;
    guard = 0;
    while (req_ready[n] !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (req_ready[n] !== 1'b1) begin
      check("ready_timeout", 32'(req_ready[n]), 32'h1);
      return;
    end
    e   = model_err(addr);
    idx = addr[9:2];
    exp_q.push_back({e, (!we && !e) ? model_mem[n][idx] : 32'h0});
    if (we && !e) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) model_mem[n][idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    req_valid[n] = 1'b1;
    req_we[n]    = we;
    req_addr[n]  = addr;
    req_wdata[n] = wdata;
    req_be[n]    = be;
    @(posedge clk);
    @(negedge clk);
    // Garbage on the request inputs must be ignored while busy
    req_valid[n] = 1'b0;
    req_we[n]    = 1'($urandom_range(0, 1));
    req_addr[n]  = $urandom;
    req_wdata[n] = $urandom;
    req_be[n]    = 4'($urandom_range(0, 15));
    for (int i = 0; i <= wc[n]; i++) begin
      if (i > 0) @(negedge clk);
      check("resp_valid_latency", 32'(resp_valid[n]), 32'(i == wc[n]));
      check("req_ready_busy", 32'(req_ready[n]), 32'h0);
    end
    exp = exp_q.pop_front();
    check("resp_rdata", resp_rdata[n], exp[31:0]);
    check("resp_err", 32'(resp_err[n]), 32'(exp[32]));
    held_rdata = resp_rdata[n];
    held_err   = resp_err[n];
    rdata_out  = resp_rdata[n];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(resp_valid[n]), 32'h1);
      check("hold_rdata", resp_rdata[n], held_rdata);
      check("hold_err", 32'(resp_err[n]), 32'(held_err));
      check("hold_req_ready", 32'(req_ready[n]), 32'h0);
    end
    resp_ready[n] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready[n] = 1'b0;
    check_idle_outputs(n, "after_hs");
    check("after_hs_req_ready", 32'(req_ready[n]), 32'h1);
  endtask

  // Abort a store by reset, either while waiting or after it has committed.
  task automatic reset_mid_op(input logic [31:0] addr, input logic [31:0] wdata,
                              input int edges_before_rst);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = addr;
    req_wdata[0] = wdata;
    req_be[0]    = 4'hf;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (edges_before_rst) @(negedge clk);
    check("pre_rst_valid", 32'(resp_valid[0]), 32'(edges_before_rst == wc[0]));
    if (edges_before_rst >= wc[0]) model_mem[0][addr[9:2]] = wdata;
    rst[0] = 1'b1;
    @(negedge clk);
    check_idle_outputs(0, "mid_rst");
    check("mid_rst_req_ready", 32'(req_ready[0]), 32'h0);
    rst[0] = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 32'(req_ready[0]), 32'h1);
  endtask

  // Main sequence
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    wc[0] = 2;
    wc[1] = 0;
    for (int n = 0; n < 2; n++) begin
      rst[n]        = 1'b1;
      req_valid[n]  = 1'b0;
      req_we[n]     = 1'b0;
      req_addr[n]   = 32'h0;
      req_wdata[n]  = 32'h0;
      req_be[n]     = 4'h0;
      resp_ready[n] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      check_idle_outputs(n, "reset");
      check("reset_req_ready", 32'(req_ready[n]), 32'h0);
      rst[n] = 1'b0;
    end
    @(negedge clk);
    for (int n = 0; n < 2; n++) check("ready_after_reset", 32'(req_ready[n]), 32'h1);

    // Bring both RAMs to a known all-zero image
    for (int n = 0; n < 2; n++) begin
      for (int w = 0; w < 256; w++) do_txn(n, 1'b1, 32'(w) << 2, 32'h0, 4'hf, 0, got);
    end

    // Store then load
    do_txn(0, 1'b1, 32'h10, 32'h0000_0012, 4'hf, 0, got);
    check("plan_store_rdata", got, 32'h0);
    do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, got);
    check("plan_load_back", got, 32'h0000_0012);

    // Byte-enable merge
    do_txn(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'hf, 0, got);
    do_txn(0, 1'b1, 32'h20, 32'h1122_3344, 4'b0101, 0, got);
    do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, got);
    check("plan_be_merge", got, 32'hAA22_CC44);
    do_txn(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 0, got);
    do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, got);
    check("plan_be_none", got, 32'hAA22_CC44);

    // Misaligned and out-of-range accesses
    do_txn(0, 1'b0, 32'h13, 32'h0, 4'hf, 0, got);
    check("plan_misaligned_rdata", got, 32'h0);
    do_txn(0, 1'b1, 32'h400, 32'hDEAD_BEEF, 4'hf, 0, got);
    do_txn(0, 1'b0, 32'h000, 32'h0, 4'h0, 0, got);
    check("plan_oor_no_alias", got, 32'h0);

    // Back-pressure on the response channel
    do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 5, got);

    // Reset during WAIT drops the store; reset during RESP keeps it
    reset_mid_op(32'h08, 32'h1234_5678, 0);
    do_txn(0, 1'b0, 32'h08, 32'h0, 4'h0, 0, got);
    check("plan_rst_wait_nowrite", got, 32'h0);
    reset_mid_op(32'h0C, 32'hCAFE_F00D, 2);
    do_txn(0, 1'b0, 32'h0C, 32'h0, 4'h0, 0, got);
    check("plan_rst_resp_kept", got, 32'hCAFE_F00D);

    // Zero wait states: single access, then back-to-back requests
    do_txn(1, 1'b1, 32'h10, 32'h0000_0055, 4'hf, 0, got);
    do_txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 2, got);
    check("w0_load", got, 32'h0000_0055);
    req_valid[1]  = 1'b1;
    req_we[1]     = 1'b0;
    req_addr[1]   = 32'h10;
    req_be[1]     = 4'h0;
    resp_ready[1] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("b2b_valid", 32'(resp_valid[1]), 32'(c % 2 == 0));
      check("b2b_req_ready", 32'(req_ready[1]), 32'(c % 2 == 1));
      if (c % 2 == 0) check("b2b_rdata", resp_rdata[1], 32'h0000_0055);
    end
    req_valid[1]  = 1'b0;
    resp_ready[1] = 1'b0;
    @(negedge clk);

    // Randomized traffic against the model
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 60; k++) begin
        logic [31:0] addr;
        case ($urandom_range(0, 9))
          0:       addr = {22'h0, 8'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
          1:       addr = (32'($urandom_range(1, 4194303)) << 10) | 32'($urandom_range(0, 1023));
          2:       addr = 32'h8000_0000 | {22'h0, 8'($urandom_range(0, 255)), 2'b00};
          default: addr = {22'h0, 8'($urandom_range(0, 15)), 2'b00};
        endcase
        do_txn(n, 1'($urandom_range(0, 1)), addr, $urandom,
               4'($urandom_range(0, 15)), $urandom_range(0, 3), got);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
